// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    // Slot PC storage is sized for the widest supported XLEN; narrower PCs are zero-extended.
    localparam int unsigned SLOT_XLEN = 64;
    localparam int unsigned INSTR_W   = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [SLOT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]   instr;
        logic                 filled;
    } fetch_slot_t;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_JAL,
        REDIR_EX
    } redirect_src_e;

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch slot queue: slots are allocated at request grant, filled on response, popped to ID.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill,
    input  logic [INSTR_W-1:0]       fill_instr,
    input  logic                     pop,
    output logic                     head_filled_c,
    output logic [INSTR_W-1:0]       head_instr_c,
    output logic [XLEN-1:0]          head_pc_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_slot_t      slots [DEPTH];
    fetch_slot_t      head_slot_c;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] tail;

    // Slot state and pointers; flush frees every slot so nothing stale can reach the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            fill_ptr <= '0;
            tail     <= '0;
            count    <= '0;
            pending  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            head     <= tail;
            fill_ptr <= tail;
            count    <= '0;
            pending  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i].filled <= 1'b0;
                slots[i].instr  <= NOP_INSTR;
            end
        end else begin
            if (alloc) begin
                slots[tail].pc     <= SLOT_XLEN'(alloc_pc);
                slots[tail].filled <= 1'b0;
                tail               <= tail + PTR_W'(1);
            end
            if (fill) begin
                slots[fill_ptr].instr  <= fill_instr;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + PTR_W'(1);
            end
            // Popped slots are cleared so an empty queue never shows a filled head.
            if (pop) begin
                slots[head].filled <= 1'b0;
                head               <= head + PTR_W'(1);
            end
            count   <= count + CNT_W'(alloc) - CNT_W'(pop);
            pending <= pending + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    always_comb begin
        head_slot_c   = slots[head];
        head_filled_c = head_slot_c.filled;
        head_instr_c  = head_slot_c.instr;
        head_pc_c     = XLEN'(head_slot_c.pc);
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Pipelined instruction fetch: issues imem requests, buffers in-order responses and resolves redirects.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     FETCH_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_redirect_i,
    input  logic [XLEN-1:0]    ex_target_i,
    input  logic               id_jal_i,
    input  logic [XLEN-1:0]    id_jal_target_i,
    output logic               imem_req_o,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [31:0]        imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [XLEN-1:0]    instr_pc_o,
    output logic [XLEN-1:0]    instr_pc_plus4_o
);

    localparam int unsigned CNT_W = $clog2(FETCH_DEPTH) + 1;

    logic [XLEN-1:0]    fetch_pc;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   pending;
    redirect_src_e      src_c;
    logic               redirect_c;
    logic [XLEN-1:0]    target_c;
    logic               credit_c;
    logic               alloc_c;
    logic               fill_c;
    logic               pop_c;
    logic               head_filled_c;
    logic [INSTR_W-1:0] head_instr_c;
    logic [XLEN-1:0]    head_pc_c;

    // Redirect select: EX is older than ID, so it wins; targets are forced word-aligned.
    always_comb begin
        src_c    = REDIR_NONE;
        target_c = '0;
        if (ex_redirect_i) begin
            src_c = REDIR_EX;
        end else if (id_jal_i) begin
            src_c = REDIR_JAL;
        end
        case (src_c)
            REDIR_EX:  target_c = {ex_target_i[XLEN-1:2], 2'b00};
            REDIR_JAL: target_c = {id_jal_target_i[XLEN-1:2], 2'b00};
            default:   target_c = '0;
        endcase
    end

    assign redirect_c = (src_c != REDIR_NONE);

    // Stale in-flight responses still occupy a credit until they come back.
    assign credit_c   = ((CNT_W+1)'(count) + (CNT_W+1)'(drop_cnt)) < (CNT_W+1)'(FETCH_DEPTH);
    assign imem_req_o = !rst && !redirect_c && credit_c;
    assign imem_addr_o = fetch_pc;

    assign alloc_c = imem_req_o && imem_gnt_i;
    assign fill_c  = imem_rvalid_i && !redirect_c && (drop_cnt == '0);

    assign instr_valid_o    = head_filled_c && !redirect_c;
    assign pop_c            = instr_valid_o && instr_ready_i;
    assign instr_o          = head_instr_c;
    assign instr_pc_o       = head_pc_c;
    assign instr_pc_plus4_o = head_filled_c ? head_pc_c + XLEN'(4) : '0;

    // Fetch PC and count of responses owed to already-flushed slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_c) begin
            fetch_pc <= target_c;
            drop_cnt <= drop_cnt + pending - CNT_W'(imem_rvalid_i);
        end else begin
            if (alloc_c) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (imem_rvalid_i && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    if_fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (FETCH_DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .flush         (redirect_c),
        .alloc         (alloc_c),
        .alloc_pc      (fetch_pc),
        .fill          (fill_c),
        .fill_instr    (imem_rdata_i),
        .pop           (pop_c),
        .head_filled_c (head_filled_c),
        .head_instr_c  (head_instr_c),
        .head_pc_c     (head_pc_c),
        .count         (count),
        .pending       (pending)
    );

    // Every response must belong to either a dropped request or an unfilled slot.
    rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> ((drop_cnt != '0) || (pending != '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized checks of if_fetch_unit against a request/epoch level reference model.
module tb_if_fetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        id_jal_i = 1'b0;
    logic [31:0] id_jal_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pc_plus4_o;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN        (XLEN),
        .RESET_PC    (RST_PC),
        .FETCH_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_redirect_i    (ex_redirect_i),
        .ex_target_i      (ex_target_i),
        .id_jal_i         (id_jal_i),
        .id_jal_target_i  (id_jal_target_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_pc_plus4_o (instr_pc_plus4_o)
    );

    // Memory-side request record: address plus the redirect epoch it was issued in.
    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
    } req_t;

    req_t        mem_q[$];
    int unsigned epoch;
    int          buffered;
    logic [31:0] exp_issue;
    logic [31:0] exp_out;
    int          total;
    int          bad;
    int          delivered;

    bit          k_gnt, k_ready, k_rv, k_ex, k_jal;
    logic [31:0] k_ex_t, k_jal_t;
    bit          s_grant;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_knobs(input bit gnt, input bit ready, input bit rv);
        k_gnt   = gnt;
        k_ready = ready;
        k_rv    = rv;
        k_ex    = 1'b0;
        k_jal   = 1'b0;
    endtask

    // Drive one cycle's inputs just after negedge, then check outputs and advance the model.
    task automatic apply_and_check();
        bit          redir;
        bit          exp_req;
        bit          exp_valid;
        int          occ;
        req_t        r;
        logic [31:0] tgt;
        redir     = k_ex || k_jal;
        occ       = mem_q.size() + buffered;
        exp_req   = !redir && (occ < int'(DEPTH));
        exp_valid = !redir && (buffered > 0);
        imem_gnt_i      = k_gnt;
        instr_ready_i   = k_ready;
        ex_redirect_i   = k_ex;
        ex_target_i     = k_ex_t;
        id_jal_i        = k_jal;
        id_jal_target_i = k_jal_t;
        imem_rvalid_i   = k_rv && (mem_q.size() > 0);
        if (imem_rvalid_i) begin
            r = mem_q.pop_front();
            imem_rdata_i = mem_word(r.addr);
            if (!redir && r.epoch == epoch) buffered++;
        end else begin
            imem_rdata_i = $urandom();
        end
        #1;
        check("req", imem_req_o, exp_req);
        check("valid", instr_valid_o, exp_valid);
        s_grant = imem_req_o && imem_gnt_i;
        if (s_grant) check("addr", imem_addr_o, exp_issue);
        if (instr_valid_o && instr_ready_i) begin
            check("pc", instr_pc_o, exp_out);
            check("instr", instr_o, mem_word(exp_out));
            check("pc4", instr_pc_plus4_o, exp_out + 32'd4);
            exp_out = exp_out + 32'd4;
            buffered--;
            delivered++;
        end
        if (s_grant) begin
            mem_q.push_back('{addr: exp_issue, epoch: epoch});
            exp_issue = exp_issue + 32'd4;
        end
        if (redir) begin
            tgt       = k_ex ? k_ex_t : k_jal_t;
            tgt[1:0]  = 2'b00;
            exp_issue = tgt;
            exp_out   = tgt;
            epoch++;
            buffered  = 0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            apply_and_check();
            advance();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_knobs(1'b0, 1'b0, 1'b0);
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
        ex_redirect_i = 1'b0; id_jal_i = 1'b0;
        mem_q.delete();
        epoch++;
        buffered  = 0;
        exp_issue = RST_PC;
        exp_out   = RST_PC;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", imem_req_o, 32'd0);
        check("rst_valid", instr_valid_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        check("rst_pc4", instr_pc_plus4_o, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int  grants;
        bit  seen;
        int  r;
        total = 0; bad = 0; delivered = 0; epoch = 0; buffered = 0;
        k_ex_t = '0; k_jal_t = '0;
        @(negedge clk);
        do_reset();

        // First cycle out of reset.
        set_knobs(1'b0, 1'b0, 1'b0);
        apply_and_check();
        check("t1_req", imem_req_o, 32'd1);
        check("t1_addr", imem_addr_o, 32'h100);
        check("t1_valid", instr_valid_o, 32'd0);
        advance();

        // Streaming, one-cycle memory latency.
        set_knobs(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply_and_check();
            if (i >= 2) begin
                check("t2_valid", instr_valid_o, 32'd1);
                check("t2_pc", instr_pc_o, 32'h100 + 32'(4 * (i - 2)));
            end
            advance();
        end

        // Stall fills the queue, then resume.
        set_knobs(1'b0, 1'b1, 1'b1);
        step(6);
        exp_issue = exp_issue;
        begin
            logic [31:0] s;
            s = exp_issue;
            grants = 0;
            set_knobs(1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 8; i++) begin
                apply_and_check();
                grants += int'(s_grant);
                advance();
            end
            check("t3_grants", 32'(grants), 32'd4);
            apply_and_check();
            check("t3_full_req", imem_req_o, 32'd0);
            advance();
            set_knobs(1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 4; k++) begin
                apply_and_check();
                check("t3_valid", instr_valid_o, 32'd1);
                check("t3_pc", instr_pc_o, s + 32'(4 * k));
                if (k == 1) check("t3_resume", imem_req_o, 32'd1);
                advance();
            end
        end

        // EX redirect with two unfilled requests in flight.
        set_knobs(1'b0, 1'b1, 1'b1);
        step(6);
        set_knobs(1'b1, 1'b1, 1'b0);
        step(2);
        k_ex = 1'b1; k_ex_t = 32'h2000;
        apply_and_check();
        check("t4_redir_req", imem_req_o, 32'd0);
        check("t4_redir_valid", instr_valid_o, 32'd0);
        advance();
        set_knobs(1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            apply_and_check();
            if (instr_valid_o && !seen) begin
                check("t4_first_pc", instr_pc_o, 32'h2000);
                seen = 1'b1;
            end
            advance();
        end
        check("t4_seen", 32'(seen), 32'd1);

        // Redirect priority and target alignment.
        set_knobs(1'b0, 1'b1, 1'b1);
        step(6);
        k_ex = 1'b1; k_ex_t = 32'h3000; k_jal = 1'b1; k_jal_t = 32'h4000;
        step(1);
        set_knobs(1'b0, 1'b1, 1'b1);
        apply_and_check();
        check("t5_prio", imem_addr_o, 32'h3000);
        advance();
        k_ex = 1'b1; k_ex_t = 32'h1003;
        step(1);
        set_knobs(1'b0, 1'b1, 1'b1);
        apply_and_check();
        check("t5_align", imem_addr_o, 32'h1000);
        advance();
        k_jal = 1'b1; k_jal_t = 32'h4002;
        step(1);
        set_knobs(1'b0, 1'b1, 1'b1);
        apply_and_check();
        check("t5_jal", imem_addr_o, 32'h4000);
        advance();

        // Response coincident with redirect, one more still in flight.
        set_knobs(1'b1, 1'b1, 1'b0);
        step(2);
        set_knobs(1'b1, 1'b1, 1'b1);
        k_ex = 1'b1; k_ex_t = 32'h6000;
        step(1);
        set_knobs(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_and_check();
            check("t6_no_stale", instr_valid_o, 32'd0);
            advance();
        end
        set_knobs(1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_and_check();
            if (instr_valid_o && !seen) begin
                check("t6_first_pc", instr_pc_o, 32'h6000);
                seen = 1'b1;
            end
            advance();
        end
        check("t6_seen", 32'(seen), 32'd1);

        // Fetch PC wrap.
        set_knobs(1'b1, 1'b1, 1'b1);
        k_ex = 1'b1; k_ex_t = 32'hFFFF_FFF8;
        step(1);
        set_knobs(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply_and_check();
            if (i < 3) check("t7_addr", imem_addr_o, 32'hFFFF_FFF8 + 32'(4 * i));
            advance();
        end

        // Mid-stream reset.
        do_reset();
        set_knobs(1'b0, 1'b0, 1'b0);
        apply_and_check();
        check("rst2_addr", imem_addr_o, RST_PC);
        advance();

        // Randomized traffic against the model.
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            r       = int'($urandom_range(0, 99));
            k_gnt   = ($urandom_range(0, 9) < 7);
            k_ready = ($urandom_range(0, 9) < 7);
            k_rv    = ($urandom_range(0, 9) < 6);
            k_ex    = (r < 4);
            k_jal   = (r >= 2) && (r < 7);
            k_ex_t  = $urandom();
            k_jal_t = $urandom();
            apply_and_check();
            advance();
        end
        check("progress", 32'(delivered > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
